alu_rs: RTL
===========

ALU_RS -- requirements
Module: alu_rs

Interface -- parameters
REQ-001 SHALL: DatapathWidth, 32, operand/result width.
REQ-002 SHALL: AluOperationWidth, 5, ALU operation code width.
REQ-003 SHALL: TagWidth, 3, CDB producer tag width.
REQ-004 SHALL: NumEntries, 4, reservation station entries (power of two, >=2).

Interface -- ports
REQ-005 SHALL: clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL: rst_i  in  1  synchronous, active-high reset.
REQ-007 SHALL: flush_i  in  1  discard all entries.
REQ-008 SHALL: dispatch_valid_i / dispatch_ready_o  in/out  1  dispatch handshake.
REQ-009 SHALL: dispatch_operation_i  in  AluOperationWidth  ALU operation.
REQ-010 SHALL: dispatch_tag_i  in  TagWidth  destination tag of this instruction.
REQ-011 SHALL: dispatch_op{1,2}_i  in  DatapathWidth  operand value when valid.
REQ-012 SHALL: dispatch_op{1,2}_valid_i / dispatch_op{1,2}_tag_i  in  1/TagWidth  operand present, else producer tag.
REQ-013 SHALL: dispatch_immediate_i, dispatch_pc_i  in  DatapathWidth  immediate, PC.
REQ-014 SHALL: cdb_valid_i / cdb_tag_i / cdb_result_i  in  1/TagWidth/DatapathWidth  result broadcast.
REQ-015 SHALL: issue_valid_o  out  1  issue fields below carry an instruction this cycle.
REQ-016 SHALL: operation_o, operand1_o, operand2_o, immediate_o, pc_o, issue_tag_o  out  ALU-facing fields of the issued instruction.

Function
REQ-017 SHALL: each entry is in state FREE, WAIT (>=1 operand missing) or READY (both operands present).
REQ-018 SHALL: dispatch_ready_o = 1 iff at least one entry is FREE at the start of the cycle; an entry freed by issue is not reusable in the same cycle.
REQ-019 SHALL: on dispatch_valid_i&&dispatch_ready_o, write the lowest-index FREE entry; next state READY if both operands present, else WAIT.
REQ-020 SHALL: a CDB broadcast whose tag matches a missing dispatch operand in the same cycle supplies that operand (same-cycle bypass).
REQ-021 SHALL: every cycle cdb_valid_i=1, each WAIT entry captures cdb_result_i into every missing operand whose tag equals cdb_tag_i; one broadcast may fill both operands.
REQ-022 SHALL: issue_valid_o = 1 iff any entry is READY; the selected entry goes FREE at the next edge.
REQ-023 SHALL: issue outputs are combinational from entry state; issue_valid_o=0 drives all issue fields to 0.
REQ-024 SHALL: minimum latency: dispatch with both operands present in cycle t issues at t+1; CDB wakeup in cycle t issues at t+1.
REQ-025 SHALL: at most one dispatch and one issue per cycle; both may occur in the same cycle on different entries.
REQ-026 SHALL: flush_i=1 frees all entries at the next edge, ignores dispatch and CDB that cycle, and forces issue_valid_o=0 in that cycle.
REQ-027 SHALL: dispatch_valid_i with dispatch_ready_o=0 writes nothing; the dispatcher holds its fields stable until accepted.

Reset
REQ-028 SHALL: rst_i=1 at a clock edge frees all entries, clears stored data and age state, and has priority over flush, dispatch and CDB.
REQ-029 SHALL: after reset, dispatch_ready_o=1, issue_valid_o=0 and all issue fields are 0; reset asserted mid-operation drops in-flight entries.

Configuration
REQ-030 SHALL: macro ALU_RS_OLDEST_FIRST_EN defined: among READY entries, issue the oldest dispatched (per-entry age tracking).
REQ-031 SHALL: macro ALU_RS_OLDEST_FIRST_EN undefined: issue the lowest-index READY entry; no age state is synthesized.

Verification
REQ-032 SHALL: reset, then dispatch ADD op1=5 op2=7 both valid, tag=2 -> next cycle issue_valid_o=1, operation_o=0, operand1_o=5, operand2_o=7, issue_tag_o=2; entry FREE after.
REQ-033 SHALL: dispatch with op1 waiting on tag 3; CDB tag 3 result 0x10 two cycles later -> issue the cycle after the CDB, operand1_o=0x10.
REQ-034 SHALL: dispatch with op2 waiting on tag 1 while cdb_valid_i=1, tag 1, result 9 in the same cycle -> issue next cycle, operand2_o=9.
REQ-035 SHALL: fill 4 entries all waiting -> dispatch_ready_o=0 and a fifth dispatch is not written; one CDB wakeup -> issue, then dispatch_ready_o=1 the following cycle.
REQ-036 SHALL: with ALU_RS_OLDEST_FIRST_EN, entries 2 then 0 dispatched and both woken by the same CDB -> entry 2 issues first; without the macro -> entry 0 issues first.
REQ-037 SHALL: flush_i asserted with 3 occupied entries -> issue_valid_o=0 that cycle, all free next cycle; rst_i mid-stream -> outputs 0 and dispatch_ready_o=1 next cycle.

Source files
------------

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB and issue signals of the ALU reservation station.
interface alu_rs_if #(
  parameter int DatapathWidth     = 32,
  parameter int AluOperationWidth = 5,
  parameter int TagWidth          = 3
);
  logic                         dispatch_valid_i;
  logic                         dispatch_ready_o;
  logic [AluOperationWidth-1:0] dispatch_operation_i;
  logic [TagWidth-1:0]          dispatch_tag_i;
  logic [DatapathWidth-1:0]     dispatch_op1_i;
  logic [DatapathWidth-1:0]     dispatch_op2_i;
  logic                         dispatch_op1_valid_i;
  logic                         dispatch_op2_valid_i;
  logic [TagWidth-1:0]          dispatch_op1_tag_i;
  logic [TagWidth-1:0]          dispatch_op2_tag_i;
  logic [DatapathWidth-1:0]     dispatch_immediate_i;
  logic [DatapathWidth-1:0]     dispatch_pc_i;
  logic                         cdb_valid_i;
  logic [TagWidth-1:0]          cdb_tag_i;
  logic [DatapathWidth-1:0]     cdb_result_i;
  logic                         issue_valid_o;
  logic [AluOperationWidth-1:0] operation_o;
  logic [DatapathWidth-1:0]     operand1_o;
  logic [DatapathWidth-1:0]     operand2_o;
  logic [DatapathWidth-1:0]     immediate_o;
  logic [DatapathWidth-1:0]     pc_o;
  logic [TagWidth-1:0]          issue_tag_o;
  modport master (
    output dispatch_valid_i, dispatch_operation_i, dispatch_tag_i, dispatch_op1_i, dispatch_op2_i,
           dispatch_op1_valid_i, dispatch_op2_valid_i, dispatch_op1_tag_i, dispatch_op2_tag_i,
           dispatch_immediate_i, dispatch_pc_i, cdb_valid_i, cdb_tag_i, cdb_result_i,
    input  dispatch_ready_o, issue_valid_o, operation_o, operand1_o, operand2_o, immediate_o, pc_o,
           issue_tag_o
  );
  modport slave (
    input  dispatch_valid_i, dispatch_operation_i, dispatch_tag_i, dispatch_op1_i, dispatch_op2_i,
           dispatch_op1_valid_i, dispatch_op2_valid_i, dispatch_op1_tag_i, dispatch_op2_tag_i,
           dispatch_immediate_i, dispatch_pc_i, cdb_valid_i, cdb_tag_i, cdb_result_i,
    output dispatch_ready_o, issue_valid_o, operation_o, operand1_o, operand2_o, immediate_o, pc_o,
           issue_tag_o
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup and same-cycle dispatch bypass.
// ALU_RS_OLDEST_FIRST_EN selects oldest-ready issue (age matrix); default is lowest-index ready.
module alu_rs #(
  parameter int DatapathWidth     = 32,
  parameter int AluOperationWidth = 5,
  parameter int TagWidth          = 3,
  parameter int NumEntries        = 4
) (
  input logic   clk_i,
  input logic   rst_i,
  input logic   flush_i,
  alu_rs_if.slave rs
);
  localparam int IdxWidth = $clog2(NumEntries);
  typedef enum logic [1:0] {FREE, WAIT, READY} state_e;
  typedef struct packed {
    state_e                       st;
    logic [AluOperationWidth-1:0] op;
    logic [TagWidth-1:0]          tag;
    logic                         v1;
    logic                         v2;
    logic [TagWidth-1:0]          t1;
    logic [TagWidth-1:0]          t2;
    logic [DatapathWidth-1:0]     o1;
    logic [DatapathWidth-1:0]     o2;
    logic [DatapathWidth-1:0]     imm;
    logic [DatapathWidth-1:0]     pc;
  } entry_t;
  entry_t ent_q [NumEntries];
  entry_t ent_d [NumEntries];
  entry_t new_ent;
  logic [NumEntries-1:0] free, rdy;
  logic [IdxWidth-1:0] alloc_idx, iss_idx;
  logic iss_v, fire, hit1, hit2;
`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [NumEntries-1:0] older_q [NumEntries];
  logic [NumEntries-1:0] older_d [NumEntries];
`endif
  always_comb begin
    free = '0;
    rdy = '0;
    alloc_idx = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      free[i] = ent_q[i].st == FREE;
      rdy[i] = ent_q[i].st == READY;
      if (ent_q[i].st == FREE) alloc_idx = IdxWidth'(i);
    end
  end
  always_comb begin
    iss_v = 1'b0;
    iss_idx = '0;
    for (int i = NumEntries - 1; i >= 0; i--)
`ifdef ALU_RS_OLDEST_FIRST_EN
      if (rdy[i] && (rdy & ~older_q[i] & ~(NumEntries'(1) << i)) == '0) begin
`else
      if (rdy[i]) begin
`endif
        iss_v = !flush_i;
        iss_idx = IdxWidth'(i);
      end
  end
  assign rs.dispatch_ready_o = |free;
  assign fire = rs.dispatch_valid_i && rs.dispatch_ready_o && !flush_i;
  assign hit1 = rs.cdb_valid_i && rs.cdb_tag_i == rs.dispatch_op1_tag_i;
  assign hit2 = rs.cdb_valid_i && rs.cdb_tag_i == rs.dispatch_op2_tag_i;
  // A missing operand whose producer broadcasts this cycle is taken straight from the CDB
  always_comb begin
    new_ent = '{
      st:  ((rs.dispatch_op1_valid_i || hit1) && (rs.dispatch_op2_valid_i || hit2)) ? READY : WAIT,
      op:  rs.dispatch_operation_i,
      tag: rs.dispatch_tag_i,
      v1:  rs.dispatch_op1_valid_i || hit1,
      v2:  rs.dispatch_op2_valid_i || hit2,
      t1:  rs.dispatch_op1_tag_i,
      t2:  rs.dispatch_op2_tag_i,
      o1:  rs.dispatch_op1_valid_i ? rs.dispatch_op1_i : rs.cdb_result_i,
      o2:  rs.dispatch_op2_valid_i ? rs.dispatch_op2_i : rs.cdb_result_i,
      imm: rs.dispatch_immediate_i,
      pc:  rs.dispatch_pc_i
    };
  end
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < NumEntries; i++)
      if (ent_q[i].st == WAIT && rs.cdb_valid_i) begin
        if (!ent_q[i].v1 && ent_q[i].t1 == rs.cdb_tag_i) begin
          ent_d[i].v1 = 1'b1;
          ent_d[i].o1 = rs.cdb_result_i;
        end
        if (!ent_q[i].v2 && ent_q[i].t2 == rs.cdb_tag_i) begin
          ent_d[i].v2 = 1'b1;
          ent_d[i].o2 = rs.cdb_result_i;
        end
        ent_d[i].st = (ent_d[i].v1 && ent_d[i].v2) ? READY : WAIT;
      end
    if (iss_v) ent_d[iss_idx].st = FREE;
    if (fire) ent_d[alloc_idx] = new_ent;
    if (flush_i) for (int i = 0; i < NumEntries; i++) ent_d[i].st = FREE;
  end
`ifdef ALU_RS_OLDEST_FIRST_EN
  // older_q[i][j] set means entry i was dispatched before entry j
  always_comb begin
    older_d = older_q;
    if (fire) begin
      older_d[alloc_idx] = '0;
      for (int j = 0; j < NumEntries; j++)
        if (IdxWidth'(j) != alloc_idx) older_d[j][alloc_idx] = 1'b1;
    end
  end
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumEntries; i++) ent_q[i] <= '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
      for (int i = 0; i < NumEntries; i++) older_q[i] <= '0;
`endif
    end else begin
      ent_q <= ent_d;
`ifdef ALU_RS_OLDEST_FIRST_EN
      older_q <= older_d;
`endif
    end
  end
  assign rs.issue_valid_o = iss_v;
  assign rs.operation_o = iss_v ? ent_q[iss_idx].op : '0;
  assign rs.operand1_o = iss_v ? ent_q[iss_idx].o1 : '0;
  assign rs.operand2_o = iss_v ? ent_q[iss_idx].o2 : '0;
  assign rs.immediate_o = iss_v ? ent_q[iss_idx].imm : '0;
  assign rs.pc_o = iss_v ? ent_q[iss_idx].pc : '0;
  assign rs.issue_tag_o = iss_v ? ent_q[iss_idx].tag : '0;
endmodule
